macro_credit_cnt4: RTL

- 4-bit credit counter for a small downstream buffer (up to 15 entries).
- Upstream issue requests take one credit; downstream release returns one.
- The next-state value comes from the team's 4-bit increment/decrement ROM. The block drives it as the consumer stage: `d` = current count, `dec` = select line.
- Produces a registered acquire handshake, full/empty flags and a sticky error flag.

---
 rtl/macro_credit_cnt4.sv | 89 ++++++++
 1 files changed

// File: rtl/macro_credit_cnt4.sv
`default_nettype none
// +------------------------------------------------------------------+
// | macro_credit_cnt4 / incdec_rom4: 4-bit credit counter with ROM    |
// | based next-state.                                    Rev 1.0      |
// +------------------------------------------------------------------+

module incdec_rom4 (
  input  logic [3:0] d,
  input  logic       dec,
  output logic [3:0] q,
  output logic       carry
);
  // carry doubles as borrow when decrementing through zero
  assign {carry, q} = dec ? ({1'b0, d} - 5'd1) : ({1'b0, d} + 5'd1);
endmodule

module macro_credit_cnt4 #(
  parameter logic [3:0] INIT_CREDIT = 4'd8,
  parameter logic [3:0] MAX_CREDIT  = 4'd15
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       i_acquire_valid,
  output logic       o_acquire_ready,
  input  logic       i_release,
  input  logic       i_reload,
  input  logic [3:0] i_reload_val,
  input  logic       i_err_clr,
  output logic [3:0] o_credit,
  output logic       o_empty,
  output logic       o_full,
  output logic       o_err
);

  logic [3:0] r_credit;
  logic       r_err;
  logic       w_fire;
  logic       w_dec;
  logic       w_full;
  logic       w_inc_ok;
  logic       w_commit;
  logic       w_err_set;
  logic [3:0] w_reload_sat;
  logic [3:0] w_rom_q;
  logic       w_rom_carry;

  assign w_full          = (r_credit == MAX_CREDIT);
  assign o_acquire_ready = (r_credit != 4'd0);
  assign w_fire          = i_acquire_valid & o_acquire_ready;
  assign w_dec           = w_fire & ~i_release;
  assign w_inc_ok        = i_release & ~w_fire & ~w_full;
  assign w_commit        = ~i_reload & (w_dec | w_inc_ok);
  assign w_reload_sat    = (i_reload_val > MAX_CREDIT) ? MAX_CREDIT : i_reload_val;

  // overflow release, or a request that can neither fire nor be covered by a return
  assign w_err_set = (i_release & ~w_fire & w_full)
                   | (i_acquire_valid & ~o_acquire_ready & ~i_release);

  incdec_rom4 u_rom (
    .d     (r_credit),
    .dec   (w_dec),
    .q     (w_rom_q),
    .carry (w_rom_carry)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_credit <= INIT_CREDIT;
      r_err    <= 1'b0;
    end else if (i_reload) begin
      r_credit <= w_reload_sat;
    end else begin
      if (w_commit) r_credit <= w_rom_q;
      if (w_err_set)      r_err <= 1'b1;
      else if (i_err_clr) r_err <= 1'b0;
    end
  end

  assign o_credit = r_credit;
  assign o_empty  = (r_credit == 4'd0);
  assign o_full   = w_full;
  assign o_err    = r_err;

  a_no_carry_at_commit : assert property (
    @(posedge clk) disable iff (!resetn) w_commit |-> !w_rom_carry
  );

endmodule
`default_nettype wire
